// File: rtl/uart_rx_stream_pkg.sv
// Shared types for the UART receive path: FSM state encoding and counter sizing helper.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_rx_stream_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic int cnt_width(input int n);
    cnt_width = (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_byte_fifo.sv
// Synchronous byte FIFO with flush, registered (non-FWFT) read data and registered count/empty/full.
module uart_rx_byte_fifo #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full
);
  import uart_rx_stream_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, full_q;
  logic [WIDTH-1:0]  rd_data_q;
  logic              wr_ok, rd_ok;

  // A write into a full FIFO is only accepted when a pop frees the head slot in the same cycle.
  always_comb begin
    wr_ok   = wr_en && (!full_q || rd_en) && !flush;
    rd_ok   = rd_en && !empty_q && !flush;
    count_d = count_q;
    if (wr_ok && !rd_ok)      count_d = count_q + CNT_ONE;
    else if (!wr_ok && rd_ok) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      rd_data_q <= '0;
    end else if (flush) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_ok) begin
        rd_ptr_q  <= rd_ptr_q + PTR_ONE;
        rd_data_q <= mem[rd_ptr_q];
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_FULL);
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;
  assign empty   = empty_q;
  assign full    = full_q;

endmodule

// File: rtl/uart_rx_stream.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a byte FIFO,
// with single-cycle frame_error / overrun pulses.
module uart_rx_stream #(
  parameter int BUFFER_WIDTH    = 8,
  parameter int CLK_FREQ        = 10_000_000,
  parameter int BAUD            = 115_200,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      uart_rst,
  input  logic                      rxd,
  output logic [BUFFER_WIDTH-1:0]   uart_data_out,
  output logic                      uart_out_empty,
  output logic                      uart_out_full,
  input  logic                      uart_out_read,
  output logic [FIFO_ADDR_WIDTH:0]  fifo_count,
  output logic                      frame_error,
  output logic                      overrun
);
  import uart_rx_stream_pkg::*;

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  rx_state_e               state_q, state_d;
  logic                    rx_meta_q, rx_sync_q;
  logic [CNT_W-1:0]        clk_cnt_q, clk_cnt_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [BUFFER_WIDTH-1:0] shift_q, shift_d;
  logic                    frame_error_q, overrun_q;
  logic                    push, fe_d, ov_d, stop_ok;
`ifdef UART_RX_PARITY_EN
  logic                    parity_bad_q, parity_bad_d;
  assign stop_ok = rx_sync_q && !parity_bad_q;
`else
  assign stop_ok = rx_sync_q;
`endif

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CNT_ONE;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    fe_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_sync_q) begin
          state_d   = ST_START;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        // A start bit that is high again at mid-bit is treated as a glitch.
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          state_d   = rx_sync_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[BUFFER_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d    = '0;
          parity_bad_d = rx_sync_q ^ (^shift_q);
          state_d      = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = ST_IDLE;
          if (stop_ok) push = 1'b1;
          else         fe_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (uart_rst) begin
      state_d   = ST_IDLE;
      clk_cnt_d = '0;
      push      = 1'b0;
      fe_d      = 1'b0;
    end
    ov_d = push && uart_out_full && !uart_out_read;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      state_q       <= ST_IDLE;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q  <= 1'b0;
`endif
    end else begin
      rx_meta_q     <= rxd;
      rx_sync_q     <= rx_meta_q;
      state_q       <= state_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      frame_error_q <= fe_d;
      overrun_q     <= ov_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q  <= parity_bad_d;
`endif
    end
  end

  uart_rx_byte_fifo #(
    .WIDTH  (BUFFER_WIDTH),
    .ADDR_W (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rstb    (rstb),
    .flush   (uart_rst),
    .wr_en   (push),
    .wr_data (shift_q),
    .rd_en   (uart_out_read),
    .rd_data (uart_data_out),
    .count   (fifo_count),
    .empty   (uart_out_empty),
    .full    (uart_out_full)
  );

  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream at 10 clocks per bit; parity cases enabled with UART_RX_PARITY_EN.
module tb_uart_rx_stream;
  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       uart_rst = 1'b0;
  logic       rxd = 1'b1;
  logic       uart_out_read = 1'b0;
  logic [7:0] uart_data_out;
  logic       uart_out_empty, uart_out_full, frame_error, overrun;
  logic [4:0] fifo_count;

  int compared = 0;
  int mismatched = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  uart_rx_stream #(
    .BUFFER_WIDTH    (8),
    .CLK_FREQ        (10_000_000),
    .BAUD            (1_000_000),
    .FIFO_ADDR_WIDTH (4)
  ) dut (
    .clk            (clk),
    .rstb           (rstb),
    .uart_rst       (uart_rst),
    .rxd            (rxd),
    .uart_data_out  (uart_data_out),
    .uart_out_empty (uart_out_empty),
    .uart_out_full  (uart_out_full),
    .uart_out_read  (uart_out_read),
    .fifo_count     (fifo_count),
    .frame_error    (frame_error),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_error) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic line_bits(input logic b, input int n);
    rxd = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop_b, input logic par_flip);
    line_bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) line_bits(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    line_bits((^d) ^ par_flip, CPB);
`endif
    line_bits(stop_b, CPB);
    $display("tx byte 0x%02h stop=%0b parflip=%0b", d, stop_b, par_flip);
  endtask

  task automatic pop(output logic [7:0] d);
    uart_out_read = 1'b1;
    @(posedge clk);
    #1;
    uart_out_read = 1'b0;
    @(negedge clk);
    d = uart_data_out;
    $display("rx read 0x%02h count=%0d", d, fifo_count);
  endtask

  task automatic partial_frame();
    line_bits(1'b0, CPB);
    line_bits(1'b1, CPB);
    line_bits(1'b0, 15);
    line_bits(1'b1, 3);
  endtask

  initial begin
    logic [7:0] rd;
    int fe0, ov0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_empty", 32'(uart_out_empty), 32'h1);
    check("reset_full", 32'(uart_out_full), 32'h0);
    check("reset_count", 32'(fifo_count), 32'h0);
    check("reset_data", 32'(uart_data_out), 32'h0);
    check("reset_pulses", 32'({frame_error, overrun}), 32'h0);
    @(posedge clk);
    #1;
    rstb = 1'b1;
    line_bits(1'b1, 5);

    // 1: single byte, then read, then read while empty
    fe0 = fe_cnt; ov0 = ov_cnt;
    send(8'hA5, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_count", 32'(fifo_count), 32'h1);
    check("t1_empty", 32'(uart_out_empty), 32'h0);
    pop(rd);
    check("t1_data", 32'(rd), 32'hA5);
    check("t1_empty_after", 32'(uart_out_empty), 32'h1);
    pop(rd);
    check("t1_empty_read_hold", 32'(rd), 32'hA5);
    check("t1_empty_read_count", 32'(fifo_count), 32'h0);

    // 2: back-to-back frames
    send(8'h5A, 1'b1, 1'b0);
    send(8'h0F, 1'b1, 1'b0);
    send(8'hA0, 1'b1, 1'b0);
    @(negedge clk);
    check("t2_count", 32'(fifo_count), 32'h3);
    pop(rd); check("t2_data0", 32'(rd), 32'h5A);
    pop(rd); check("t2_data1", 32'(rd), 32'h0F);
    pop(rd); check("t2_data2", 32'(rd), 32'hA0);
    check("t2_errors", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'h0);

    // 3: glitch on the line
    line_bits(1'b0, 3);
    line_bits(1'b1, 30);
    check("t3_count", 32'(fifo_count), 32'h0);
    check("t3_fe", 32'(fe_cnt - fe0), 32'h0);

    // 4: stop bit low
    send(8'h3C, 1'b0, 1'b0);
    line_bits(1'b1, 20);
    check("t4_fe", 32'(fe_cnt - fe0), 32'h1);
    check("t4_count", 32'(fifo_count), 32'h0);

    // 5: fill past full
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 17; i++) begin
      send(8'(i), 1'b1, 1'b0);
      if (i == 15) begin
        @(negedge clk);
        check("t5_full16", 32'(uart_out_full), 32'h1);
        check("t5_count16", 32'(fifo_count), 32'h10);
        check("t5_no_ov_yet", 32'(ov_cnt - ov0), 32'h0);
      end
    end
    line_bits(1'b1, 5);
    check("t5_overrun", 32'(ov_cnt - ov0), 32'h1);
    check("t5_count_after", 32'(fifo_count), 32'h10);
    for (int i = 0; i < 16; i++) begin
      pop(rd);
      check($sformatf("t5_data%0d", i), 32'(rd), 32'(i));
    end
    check("t5_empty", 32'(uart_out_empty), 32'h1);
    check("t5_fe", 32'(fe_cnt - fe0), 32'h0);

    // 6a: flush mid-frame with queued bytes
    for (int i = 0; i < 5; i++) send(8'h11 + 8'(i), 1'b1, 1'b0);
    pop(rd);
    check("t6a_first", 32'(rd), 32'h11);
    check("t6a_count4", 32'(fifo_count), 32'h4);
    fe0 = fe_cnt;
    partial_frame();
    uart_rst = 1'b1;
    @(posedge clk);
    #1;
    uart_rst = 1'b0;
    @(negedge clk);
    check("t6a_count", 32'(fifo_count), 32'h0);
    check("t6a_empty", 32'(uart_out_empty), 32'h1);
    check("t6a_data", 32'(uart_data_out), 32'h0);
    line_bits(1'b1, 30);
    check("t6a_count_idle", 32'(fifo_count), 32'h0);
    check("t6a_fe", 32'(fe_cnt - fe0), 32'h0);
    send(8'hC5, 1'b1, 1'b0);
    pop(rd);
    check("t6a_next", 32'(rd), 32'hC5);

    // 6b: async reset mid-frame with queued bytes
    for (int i = 0; i < 5; i++) send(8'h21 + 8'(i), 1'b1, 1'b0);
    pop(rd);
    check("t6b_first", 32'(rd), 32'h21);
    fe0 = fe_cnt;
    partial_frame();
    #2;
    rstb = 1'b0;
    @(negedge clk);
    check("t6b_count", 32'(fifo_count), 32'h0);
    check("t6b_empty", 32'(uart_out_empty), 32'h1);
    check("t6b_data", 32'(uart_data_out), 32'h0);
    @(posedge clk);
    #1;
    rstb = 1'b1;
    line_bits(1'b1, 30);
    check("t6b_count_idle", 32'(fifo_count), 32'h0);
    send(8'hC5, 1'b1, 1'b0);
    pop(rd);
    check("t6b_next", 32'(rd), 32'hC5);
    check("t6b_fe", 32'(fe_cnt - fe0), 32'h0);

`ifdef UART_RX_PARITY_EN
    fe0 = fe_cnt;
    send(8'h07, 1'b1, 1'b1);
    line_bits(1'b1, 5);
    check("par_bad_fe", 32'(fe_cnt - fe0), 32'h1);
    check("par_bad_count", 32'(fifo_count), 32'h0);
    send(8'h07, 1'b1, 1'b0);
    line_bits(1'b1, 5);
    check("par_ok_count", 32'(fifo_count), 32'h1);
    pop(rd);
    check("par_ok_data", 32'(rd), 32'h07);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
